// File: rtl/mem_request_master.sv
// Purpose : core-side initiator for a single-port word memory. It takes one byte-addressed
//           load or store (byte/half/word), extracts and sign-extends load data, and does a
//           read-modify-write for sub-word stores.
// Latency : counted in edges from accept to resp_valid, including the accept edge
//           (L = RD_LATENCY): error 1, word store 2, load 2+L, sub-word store 3+L.
// Backpr. : one transaction at a time. req_ready is high only in IDLE. The response is held
//           stable until resp_ready is seen.
// Ports   : clock/reset (async active-low); req_* is the pipeline request (valid/ready);
//           resp_* is the response (valid/ready); mem_read/mem_write with their addresses,
//           mem_in_data (write data) and mem_out_data (read data) form the word memory side.
module mem_request_master #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int RD_LATENCY   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDRESS_BITS+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_read_address,
  output logic [ADDRESS_BITS-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0]   mem_in_data,
  input  logic [DATA_WIDTH-1:0]   mem_out_data
);

  if (DATA_WIDTH != 32 || RD_LATENCY < 1 || RD_LATENCY > 4 || CORE < 0) begin : g_param_check
    $error("mem_request_master: needs DATA_WIDTH=32 and RD_LATENCY in 1..4");
  end

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, RESP
  } state_t;

  state_t                  r_state;
  logic                    r_req_ready;
  logic                    r_resp_valid;
  logic                    r_resp_err;
  logic [31:0]             r_resp_rdata;
  logic                    r_mem_read;
  logic                    r_mem_write;
  logic [ADDRESS_BITS-1:0] r_rd_addr;
  logic [ADDRESS_BITS-1:0] r_wr_addr;
  logic [31:0]             r_mem_in_data;
  logic [1:0]              r_cnt;
  logic [ADDRESS_BITS-1:0] r_word_addr;
  logic [1:0]              r_off;
  logic [1:0]              r_size;
  logic                    r_uns;
  logic [15:0]             r_wdata;

  logic                    w_accept;
  logic                    w_err;
  logic [ADDRESS_BITS-1:0] w_word;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [31:0]             w_load;
  logic [31:0]             w_merge;

  assign w_accept = req_valid && r_req_ready;
  assign w_word   = req_addr[ADDRESS_BITS+1:2];
  // Illegal size, or an access that is not naturally aligned. No memory access is made.
  assign w_err    = (req_size == 2'd3) ||
                    (req_size == 2'd1 && req_addr[0]) ||
                    (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  // Lane extraction and merge work on the live memory data. They are only
  // registered when the wait counter reaches zero.
  always_comb begin
    w_byte  = mem_out_data[{r_off, 3'b000} +: 8];
    w_half  = mem_out_data[{r_off[1], 4'b0000} +: 16];
    w_load  = mem_out_data;
    w_merge = mem_out_data;
    case (r_size)
      2'd0:    w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load = mem_out_data;
    endcase
    if (r_size == 2'd0) w_merge[{r_off, 3'b000} +: 8]      = r_wdata[7:0];
    else                w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_rd_addr     <= '0;
      r_wr_addr     <= '0;
      r_mem_in_data <= '0;
      r_cnt         <= '0;
      r_word_addr   <= '0;
      r_off         <= '0;
      r_size        <= '0;
      r_uns         <= 1'b0;
      r_wdata       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready  <= 1'b0;
            r_word_addr  <= w_word;
            r_off        <= req_addr[1:0];
            r_size       <= req_size;
            r_uns        <= req_unsigned;
            r_wdata      <= req_wdata[15:0];
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            if (w_err) begin
              r_resp_err   <= 1'b1;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else if (!req_write) begin
              r_mem_read <= 1'b1;
              r_rd_addr  <= w_word;
              r_state    <= RD;
            end else if (req_size == 2'd2) begin
              r_mem_in_data <= req_wdata;
              r_mem_write   <= 1'b1;
              r_wr_addr     <= w_word;
              r_state       <= WR;
            end else begin
              r_mem_read <= 1'b1;
              r_rd_addr  <= w_word;
              r_state    <= RMW_RD;
            end
          end
        end
        RD, RMW_RD: begin
          r_mem_read <= 1'b0;
          r_rd_addr  <= '0;
          r_cnt      <= 2'(RD_LATENCY - 1);
          r_state    <= (r_state == RD) ? RD_WAIT : RMW_WAIT;
        end
        RD_WAIT: begin
          if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end else begin
            r_resp_rdata <= w_load;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RMW_WAIT: begin
          if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end else begin
            r_mem_in_data <= w_merge;
            r_mem_write   <= 1'b1;
            r_wr_addr     <= r_word_addr;
            r_state       <= WR;
          end
        end
        WR: begin
          r_mem_write  <= 1'b0;
          r_wr_addr    <= '0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready         = r_req_ready;
  assign resp_valid        = r_resp_valid;
  assign resp_err          = r_resp_err;
  assign resp_rdata        = r_resp_rdata;
  assign mem_read          = r_mem_read;
  assign mem_write         = r_mem_write;
  assign mem_read_address  = r_rd_addr;
  assign mem_write_address = r_wr_addr;
  assign mem_in_data       = r_mem_in_data;

endmodule

// File: tb/tb_mem_request_master.sv
module tb_mem_request_master;
  localparam int L  = 1;
  localparam int AB = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [AB+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_read;
  logic          mem_write;
  logic [AB-1:0] mem_read_address;
  logic [AB-1:0] mem_write_address;
  logic [31:0]   mem_in_data;
  logic [31:0]   mem_out_data;

  int n_checks = 0;
  int n_errors = 0;

  mem_request_master #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(AB), .RD_LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_read(mem_read),
    .mem_write(mem_write), .mem_read_address(mem_read_address),
    .mem_write_address(mem_write_address), .mem_in_data(mem_in_data),
    .mem_out_data(mem_out_data)
  );

  always #5 clock = ~clock;

  // Memory-side model: 1024 words, read data appears L edges after the read command edge.
  logic [31:0]   mem [1024];
  logic [31:0]   rd_q [L];
  logic          mem_init = 1'b0;
  int            n_rd = 0, n_wr = 0, n_both = 0;
  logic [AB-1:0] last_raddr = '0, last_waddr = '0;

  assign mem_out_data = rd_q[L-1];

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h9E3779B9 * (i + 1);
      for (int i = 0; i < L; i++) rd_q[i] <= '0;
      mem_init <= 1'b1;
    end else begin
      for (int i = 1; i < L; i++) rd_q[i] <= rd_q[i-1];
      if (mem_read) begin
        rd_q[0]    <= mem[mem_read_address[9:0]];
        n_rd       <= n_rd + 1;
        last_raddr <= mem_read_address;
      end
      if (mem_write) begin
        mem[mem_write_address[9:0]] <= mem_in_data;
        n_wr       <= n_wr + 1;
        last_waddr <= mem_write_address;
      end
      if (mem_read && mem_write) n_both <= n_both + 1;
    end
  end

  // Reference model: a word array plus shift/mask arithmetic.
  logic [31:0] ref_mem [1024];

  function automatic logic is_err(input logic [1:0] sz, input logic [AB+1:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    v = word >> (off * 8);
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_store(input logic [31:0] old, input logic [1:0] off,
                                            input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] m;
    m = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    m = m << (off * 8);
    return (old & ~m) | ((wd << (off * 8)) & m);
  endfunction

  // Drives one request with resp_ready high. Returns the response, the edge count
  // from accept (inclusive) to resp_valid, and the memory command counts.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [AB+1:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic e, output int edges,
                         output int drd, output int dwr);
    int  rd0, wr0;
    bit  done;
    rd = '0; e = 1'b0; done = 0;
    @(negedge clock);
    rd0 = n_rd; wr0 = n_wr;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clock);
    #1 req_valid = 1'b0;
    edges = 1;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clock);
      if (resp_valid) begin
        rd = resp_rdata; e = resp_err; done = 1;
      end else begin
        @(posedge clock);
        edges++;
      end
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL timeout: no resp_valid within 30 cycles (addr=%h)", a);
    end
    @(posedge clock);
    @(negedge clock);
    drd = n_rd - rd0;
    dwr = n_wr - wr0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_handshake: ready=%b valid=%b err=%b, required 1 0 0",
               req_ready, resp_valid, resp_err);
    end
    n_checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || resp_rdata !== 32'h0 ||
        mem_in_data !== 32'h0 || mem_read_address !== '0 || mem_write_address !== '0) begin
      n_errors++;
      $display("FAIL reset_mem: rd=%b wr=%b rdata=%h wdata=%h ra=%h wa=%h, required all 0",
               mem_read, mem_write, resp_rdata, mem_in_data, mem_read_address, mem_write_address);
    end
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h9E3779B9 * (i + 1);
  endtask

  task automatic test_word_load;
    logic [31:0] rd; logic e; int ed, drd, dwr;
    run_req(1'b1, 2'd2, 1'b0, 22'h40, 32'hDEADBEEF, rd, e, ed, drd, dwr);
    ref_mem[10'h10] = 32'hDEADBEEF;
    n_checks++;
    if (ed !== 2 || dwr !== 1 || drd !== 0 || last_waddr !== 20'h10) begin
      n_errors++;
      $display("FAIL sw_timing: edges=%0d wr=%0d rd=%0d waddr=%h, required 2 1 0 00010",
               ed, dwr, drd, last_waddr);
    end
    run_req(1'b0, 2'd2, 1'b0, 22'h40, 32'h0, rd, e, ed, drd, dwr);
    n_checks++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      n_errors++;
      $display("FAIL lw_data: rdata=%h err=%b, required deadbeef 0", rd, e);
    end
    n_checks++;
    if (ed !== 2 + L || drd !== 1 || dwr !== 0 || last_raddr !== 20'h10) begin
      n_errors++;
      $display("FAIL lw_timing: edges=%0d rd=%0d wr=%0d raddr=%h, required %0d 1 0 00010",
               ed, drd, dwr, last_raddr, 2 + L);
    end
  endtask

  task automatic test_subword_loads;
    logic [31:0] rd; logic e; int ed, drd, dwr;
    logic [31:0] want [3];
    logic [1:0]  szs  [3];
    logic        unss [3];
    logic [AB+1:0] adrs [3];
    want[0] = 32'hFFFFFFDE; szs[0] = 2'd0; unss[0] = 1'b0; adrs[0] = 22'h43;
    want[1] = 32'h000000DE; szs[1] = 2'd0; unss[1] = 1'b1; adrs[1] = 22'h43;
    want[2] = 32'hFFFFDEAD; szs[2] = 2'd1; unss[2] = 1'b0; adrs[2] = 22'h42;
    for (int i = 0; i < 3; i++) begin
      run_req(1'b0, szs[i], unss[i], adrs[i], 32'h0, rd, e, ed, drd, dwr);
      n_checks++;
      if (rd !== want[i] || e !== 1'b0 || ed !== 2 + L) begin
        n_errors++;
        $display("FAIL subword_load%0d: rdata=%h err=%b edges=%0d, required %h 0 %0d",
                 i, rd, e, ed, want[i], 2 + L);
      end
    end
  endtask

  task automatic test_subword_store;
    logic [31:0] rd; logic e; int ed, drd, dwr, bad;
    run_req(1'b1, 2'd2, 1'b0, 22'h40, 32'h11223344, rd, e, ed, drd, dwr);
    ref_mem[10'h10] = 32'h11223344;
    run_req(1'b1, 2'd0, 1'b0, 22'h41, 32'hABCDEF55, rd, e, ed, drd, dwr);
    ref_mem[10'h10] = exp_store(ref_mem[10'h10], 2'd1, 2'd0, 32'hABCDEF55);
    n_checks++;
    if (mem[10'h10] !== 32'h11225544) begin
      n_errors++;
      $display("FAIL sb_merge: mem word=%h, required 11225544", mem[10'h10]);
    end
    n_checks++;
    if (drd !== 1 || dwr !== 1 || ed !== 3 + L || last_waddr !== 20'h10 || rd !== 32'h0 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL sb_timing: rd=%0d wr=%0d edges=%0d waddr=%h rdata=%h err=%b, required 1 1 %0d 00010 0 0",
               drd, dwr, ed, last_waddr, rd, e, 3 + L);
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL sb_other_words: %0d words differ from model, required 0", bad);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic e; int ed, drd, dwr;
    logic          ws  [3];
    logic [1:0]    szs [3];
    logic [AB+1:0] as  [3];
    ws[0] = 1'b0; szs[0] = 2'd2; as[0] = 22'h42;
    ws[1] = 1'b1; szs[1] = 2'd1; as[1] = 22'h43;
    ws[2] = 1'b0; szs[2] = 2'd3; as[2] = 22'h40;
    for (int i = 0; i < 3; i++) begin
      run_req(ws[i], szs[i], 1'b0, as[i], 32'hFFFFFFFF, rd, e, ed, drd, dwr);
      n_checks++;
      if (e !== 1'b1 || rd !== 32'h0 || ed !== 1 || drd !== 0 || dwr !== 0) begin
        n_errors++;
        $display("FAIL err_case%0d: err=%b rdata=%h edges=%0d rd=%0d wr=%0d, required 1 0 1 0 0",
                 i, e, rd, ed, drd, dwr);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] held; bit done; int bad;
    resp_ready = 1'b0; done = 0; held = '0; bad = 0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 22'h40;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clock);
      if (resp_valid) begin held = resp_rdata; done = 1; end
    end
    n_checks++;
    if (!done || held !== ref_mem[10'h10]) begin
      n_errors++;
      $display("FAIL bp_first: seen=%0d rdata=%h, required 1 %h", done, held, ref_mem[10'h10]);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL bp_hold: %0d of 5 cycles unstable (valid/rdata/ready), required 0", bad);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release: valid=%b ready=%b, required 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_midflight;
    logic [31:0] rd; logic e; int ed, drd, dwr, wr0;
    wr0 = n_wr;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 22'h81; req_wdata = 32'h77;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
        mem_in_data !== 32'h0 || mem_write_address !== '0 || resp_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL midreset_outputs: ready=%b valid=%b rd=%b wr=%b wdata=%h wa=%h rdata=%h, required 1 0 0 0 0 0 0",
               req_ready, resp_valid, mem_read, mem_write, mem_in_data, mem_write_address, resp_rdata);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (n_wr != wr0 || mem[10'h20] !== ref_mem[10'h20]) begin
      n_errors++;
      $display("FAIL midreset_nowrite: writes=%0d word=%h, required 0 %h",
               n_wr - wr0, mem[10'h20], ref_mem[10'h20]);
    end
    run_req(1'b0, 2'd2, 1'b0, 22'h80, 32'h0, rd, e, ed, drd, dwr);
    n_checks++;
    if (rd !== ref_mem[10'h20] || e !== 1'b0 || ed !== 2 + L) begin
      n_errors++;
      $display("FAIL midreset_after: rdata=%h err=%b edges=%0d, required %h 0 %0d",
               rd, e, ed, ref_mem[10'h20], 2 + L);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, wd, xd; logic e, w, u, xe; logic [1:0] sz; logic [AB+1:0] a;
    int ed, drd, dwr, xed, xrd, xwr, bad;
    for (int it = 0; it < 60; it++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = 22'($urandom_range(0, 4095));
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      wd = $urandom;
      if (is_err(sz, a)) begin
        xd = 32'h0; xe = 1'b1; xed = 1; xrd = 0; xwr = 0;
      end else if (!w) begin
        xd = exp_load(ref_mem[a[11:2]], a[1:0], sz, u); xe = 1'b0;
        xed = 2 + L; xrd = 1; xwr = 0;
      end else begin
        xd = 32'h0; xe = 1'b0; xwr = 1;
        xed = (sz == 2'd2) ? 2 : 3 + L;
        xrd = (sz == 2'd2) ? 0 : 1;
        ref_mem[a[11:2]] = exp_store(ref_mem[a[11:2]], a[1:0], sz, wd);
      end
      run_req(w, sz, u, a, wd, rd, e, ed, drd, dwr);
      n_checks++;
      if (rd !== xd || e !== xe) begin
        n_errors++;
        $display("FAIL rand%0d_data: w=%b sz=%0d u=%b a=%h rdata=%h err=%b, required %h %b",
                 it, w, sz, u, a, rd, e, xd, xe);
      end
      n_checks++;
      if (ed !== xed || drd !== xrd || dwr !== xwr || n_both != 0) begin
        n_errors++;
        $display("FAIL rand%0d_timing: edges=%0d rd=%0d wr=%0d both=%0d, required %0d %0d %0d 0",
                 it, ed, drd, dwr, n_both, xed, xrd, xwr);
      end
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL rand_memory: %0d words differ from model, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_loads();
    test_subword_store();
    test_errors();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
